agex_muldiv_unit: RTL

Parametrised multi-cycle execute unit that sits beside the single-cycle ALU in the AGEX stage and handles the RV32M multiply/divide group: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It takes one operation at a time over a valid/ready handshake and iterates UNROLL bits per cycle. It holds its result until the downstream writeback path accepts it. A flush from branch resolution drops any in-flight operation.

---
 rtl/agex_muldiv_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/agex_muldiv_unit.sv
// agex_muldiv_unit
// Multi-cycle RV32M multiply/divide execute unit for the AGEX stage.
// Accepts one operation at a time, iterates UNROLL bits per cycle
// (N = XLEN/UNROLL cycles) and holds the result until writeback takes it.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_valid/in_ready       operation handshake (in_op, in_a, in_b, in_rd)
//   in_flush                abandon whatever is in flight
//   out_valid/out_ready     result handshake (out_result, out_rd)
//   busy                    unit is not idle
module agex_muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int UNROLL  = 1,
  parameter int TAGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [XLEN-1:0]    in_a,
  input  logic [XLEN-1:0]    in_b,
  input  logic [TAGBITS-1:0] in_rd,
  input  logic               in_flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [TAGBITS-1:0] out_rd,
  output logic               busy
);

  localparam int N    = XLEN / UNROLL;
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [TAGBITS-1:0]  rd_q, rd_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  // x: multiplier (mul) or dividend shifting into quotient (div)
  // y: multiplicand magnitude (mul) or divisor magnitude (div)
  // acc: 2*XLEN product (mul) or partial remainder in the low bits (div)
  logic [XLEN-1:0]     x_q, x_d;
  logic [XLEN-1:0]     y_q, y_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Accept-side decode
  logic            in_sa, in_sb, in_div, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    in_div   = in_op[2];
    in_sa    = in_a[XLEN-1] & ((in_op == OP_MULH) | (in_op == OP_MULHSU) |
                               (in_op == OP_DIV)  | (in_op == OP_REM));
    in_sb    = in_b[XLEN-1] & ((in_op == OP_MULH) | (in_op == OP_DIV) |
                               (in_op == OP_REM));
    mag_a    = in_sa ? -in_a : in_a;
    mag_b    = in_sb ? -in_b : in_b;
    div_zero = in_div && (in_b == '0);
    div_ovf  = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
               (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
    // in_op[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero) special_res = in_op[1] ? in_a : '1;
    else          special_res = in_op[1] ? '0 : in_a;
  end

  // One CALC cycle worth of iteration: UNROLL shift-add or restoring steps
  logic [2*XLEN-1:0] step_acc;
  logic [XLEN-1:0]   step_x;
  logic [XLEN:0]     rem_t, sum_t;

  always_comb begin
    step_acc = acc_q;
    step_x   = x_q;
    rem_t    = '0;
    sum_t    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        rem_t  = {step_acc[XLEN-1:0], step_x[XLEN-1]};
        step_x = step_x << 1;
        if (rem_t >= {1'b0, y_q}) begin
          rem_t     = rem_t - {1'b0, y_q};
          step_x[0] = 1'b1;
        end
        step_acc = {{(XLEN-1){1'b0}}, rem_t};
      end else begin
        // Add into the upper half, keep the carry, then shift the whole
        // accumulator right so the low half fills with product bits.
        sum_t    = {1'b0, step_acc[2*XLEN-1:XLEN]} + (step_x[0] ? {1'b0, y_q} : '0);
        step_acc = {sum_t, step_acc[XLEN-1:1]};
        step_x   = step_x >> 1;
      end
    end
  end

  // Sign correction and result select for the final CALC cycle
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, remv, calc_res;

  always_comb begin
    prod = (sign_a_q ^ sign_b_q) ? -step_acc : step_acc;
    quot = (sign_a_q ^ sign_b_q) ? -step_x : step_x;
    remv = sign_a_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    case (op_q)
      OP_MUL:                       calc_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              calc_res = quot;
      default:                      calc_res = remv;
    endcase
  end

  assign in_ready   = (state_q == IDLE) && !in_flush;
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_rd     = rd_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d     = in_op;
          rd_d     = in_rd;
          sign_a_d = in_sa;
          sign_b_d = in_sb;
          x_d      = in_div ? mag_a : mag_b;
          y_d      = in_div ? mag_b : mag_a;
          acc_d    = '0;
          cnt_d    = CNTW'(N - 1);
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        x_d   = step_x;
        acc_d = step_acc;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = calc_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including a same-cycle result handshake
    if (in_flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule
